id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register for the five-stage RISC-V core. It captures the control bundle produced by the main decoder, along with the register-file read data, immediate, PC and register indices of the decode-stage instruction. It detects load-use hazards against the instruction currently in EX, inserting a bubble and stalling fetch/decode. It also supports branch flush and downstream hold, and counts load-use stall cycles for performance monitoring.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNTW, 16, width of stall counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ValidD  in  1  decode-stage instruction valid
- RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD  in  1 each  main-decoder controls
- ALUOpD  in  2  main-decoder ALU class
- funct3D  in  3  instruction bits [14:12]
- funct7b5D  in  1  instruction bit 30
- RD1D, RD2D  in  XLEN  register-file read data
- ImmExtD  in  XLEN  extended immediate
- PCD  in  XLEN  decode-stage PC
- Rs1D, Rs2D, RdD  in  5 each  register indices
- FlushE  in  1  branch taken in EX; kill the instruction entering EX
- HoldE  in  1  downstream cannot accept; freeze EX
- ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  out  1 each  registered controls
- ALUOpE  out  2; funct3E  out  3; funct7b5E  out  1
- RD1E, RD2E, ImmExtE, PCE  out  XLEN
- Rs1E, Rs2E, RdE  out  5 each
- StallD  out  1  combinational: decode/fetch must hold this cycle
- StallCnt  out  CNTW  saturating count of load-use bubble cycles

## Operation
- **Reset (asynchronous, rst_n=0):** every registered output is 0, including ValidE, all controls, all data fields and StallCnt.
- **Load-use detect, combinational:**
  - LoadUse = ValidD & ValidE & ResultSrcE & RegWriteE & (RdE != 0) & ((RdE == Rs1D) | (UseRs2 & RdE == Rs2D)).
  - UseRs2 = !ALUSrcD | MemWriteD.
- **StallD = HoldE | (LoadUse & !FlushE).**
- **Next-state priority on each rising clk edge:**
  1. FlushE=1: load a bubble.
  2. Else HoldE=1: hold all registers.
  3. Else LoadUse=1: load a bubble.
  4. Else capture all D inputs; ValidE <= ValidD.
- **Bubble:**
  - ValidE and every control output are 0, and ALUOpE=00.
  - All data and index fields are 0, so bubbles compare deterministically.
- **Invalid input (ValidD=0) captured normally:** control outputs are forced to 0; data fields are captured as presented.
- **StallCnt:**
  - Increments by 1 on each edge where LoadUse & !FlushE & !HoldE.
  - Saturates at all-ones and does not wrap.
  - Cleared only by reset.

## Timing
- Latency: one cycle. D inputs are visible on the E outputs after the next rising edge.
- StallD is valid in the same cycle as its inputs and has no register. Upstream samples it before the edge.
- A load-use stall lasts exactly one cycle, because the bubble clears ValidE. On the following cycle LoadUse=0 and the held decode instruction is captured.
- FlushE and LoadUse together: the bubble is loaded and StallD=0, so the upstream is expected to be redirected and flushed by the same FlushE.
- HoldE and LoadUse together: registers hold, StallD=1, and the counter does not increment.
- If reset is asserted mid-stall or mid-hold, outputs are 0 immediately, asynchronously. After rst_n deasserts, the first edge captures D normally.
- Rd=x0 never causes a stall.

## Test plan
- **Reset:** drive RegWriteD=1, ValidD=1, then pulse rst_n low mid-cycle → all outputs 0 immediately; StallCnt=0.
- **Pass-through:**
  - Stimulus: R-type with RegWriteD=1, ALUOpD=10, RD1D=0x11, RD2D=0x22, RdD=5.
  - Required: after one edge, RegWriteE=1, ALUOpE=10, RD1E=0x11, RD2E=0x22, RdE=5, ValidE=1, StallD=0.
- **Load-use:**
  - Stimulus: lw x6 (ResultSrcD=1, RegWriteD=1, RdD=6) followed by add with Rs1D=6.
  - Required: StallD=1 for one cycle, then ValidE=0 with all controls 0, then the add is captured. StallCnt=1.
  - Repeat with Rs2D=6 on addi (ALUSrcD=1, MemWriteD=0) → no stall.
  - Repeat with sw (MemWriteD=1, Rs2D=6) → stall.
- **x0 and flush:**
  - lw with RdD=0 followed by an Rs1D=0 consumer → no stall.
  - FlushE=1 with a valid beq in D → next cycle ValidE=0, BranchE=0.
- **Hold and priority:**
  - HoldE=1 for 3 cycles → outputs frozen, StallD=1, StallCnt unchanged.
  - FlushE=1 together with HoldE=1 → bubble loaded.
  - FlushE=1 together with LoadUse → bubble loaded, StallD=0, count unchanged.
- **Saturation:** with CNTW=4, force 20 load-use stalls → StallCnt stays at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use hazard detection,
// branch flush, downstream hold and a saturating load-use stall counter.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ValidD,
    input  logic            RegWriteD,
    input  logic            ALUSrcD,
    input  logic            MemWriteD,
    input  logic            ResultSrcD,
    input  logic            BranchD,
    input  logic [1:0]      ALUOpD,
    input  logic [2:0]      funct3D,
    input  logic            funct7b5D,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    input  logic            FlushE,
    input  logic            HoldE,
    output logic            ValidE,
    output logic            RegWriteE,
    output logic            ALUSrcE,
    output logic            MemWriteE,
    output logic            ResultSrcE,
    output logic            BranchE,
    output logic [1:0]      ALUOpE,
    output logic [2:0]      funct3E,
    output logic            funct7b5E,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            StallD,
    output logic [CNTW-1:0] StallCnt
);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            alu_src;
        logic            mem_write;
        logic            result_src;
        logic            branch;
        logic [1:0]      alu_op;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } ex_bundle_t;

    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    ex_bundle_t      ex_d, ex_q, capture;
    logic [CNTW-1:0] stall_cnt_d, stall_cnt_q;
    logic            use_rs2, load_use;

    always_comb begin
        // Stores read rs2 as data even though ALUSrc selects the immediate.
        use_rs2  = !ALUSrcD | MemWriteD;
        load_use = ValidD & ex_q.valid & ex_q.result_src & ex_q.reg_write &
                   (ex_q.rd != 5'd0) &
                   ((ex_q.rd == Rs1D) | (use_rs2 & (ex_q.rd == Rs2D)));
        StallD   = HoldE | (load_use & !FlushE);
    end

    always_comb begin
        capture            = '0;
        capture.valid      = ValidD;
        capture.reg_write  = RegWriteD  & ValidD;
        capture.alu_src    = ALUSrcD    & ValidD;
        capture.mem_write  = MemWriteD  & ValidD;
        capture.result_src = ResultSrcD & ValidD;
        capture.branch     = BranchD    & ValidD;
        capture.alu_op     = ALUOpD     & {2{ValidD}};
        capture.funct3     = funct3D;
        capture.funct7b5   = funct7b5D;
        capture.rd1        = RD1D;
        capture.rd2        = RD2D;
        capture.imm        = ImmExtD;
        capture.pc         = PCD;
        capture.rs1        = Rs1D;
        capture.rs2        = Rs2D;
        capture.rd         = RdD;

        ex_d = ex_q;
        if (FlushE)
            ex_d = '0;
        else if (HoldE)
            ex_d = ex_q;
        else if (load_use)
            ex_d = '0;
        else
            ex_d = capture;

        stall_cnt_d = stall_cnt_q;
        if (load_use && !FlushE && !HoldE && (stall_cnt_q != {CNTW{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ValidE     = ex_q.valid;
    assign RegWriteE  = ex_q.reg_write;
    assign ALUSrcE    = ex_q.alu_src;
    assign MemWriteE  = ex_q.mem_write;
    assign ResultSrcE = ex_q.result_src;
    assign BranchE    = ex_q.branch;
    assign ALUOpE     = ex_q.alu_op;
    assign funct3E    = ex_q.funct3;
    assign funct7b5E  = ex_q.funct7b5;
    assign RD1E       = ex_q.rd1;
    assign RD2E       = ex_q.rd2;
    assign ImmExtE    = ex_q.imm;
    assign PCE        = ex_q.pc;
    assign Rs1E       = ex_q.rs1;
    assign Rs2E       = ex_q.rs2;
    assign RdE        = ex_q.rd;
    assign StallCnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural model.
module tb_id_ex_stage;
    localparam int XLEN = 32;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic clk = 1'b0, rst_n = 1'b0;
    logic ValidD, RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD, funct7b5D;
    logic [1:0] ALUOpD;
    logic [2:0] funct3D;
    logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic FlushE, HoldE;
    logic ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, funct7b5E;
    logic [1:0] ALUOpE;
    logic [2:0] funct3E;
    logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE;
    logic [4:0] Rs1E, Rs2E, RdE;
    logic StallD;
    logic [CNTW-1:0] StallCnt;

    id_ex_stage #(.XLEN(XLEN), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .ValidD(ValidD), .RegWriteD(RegWriteD),
        .ALUSrcD(ALUSrcD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD),
        .BranchD(BranchD), .ALUOpD(ALUOpD), .funct3D(funct3D), .funct7b5D(funct7b5D),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .FlushE(FlushE), .HoldE(HoldE),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE),
        .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .BranchE(BranchE),
        .ALUOpE(ALUOpE), .funct3E(funct3E), .funct7b5E(funct7b5E),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .StallD(StallD), .StallCnt(StallCnt)
    );

    always #5 clk = ~clk;

    // Reference: what the EX stage should hold, in plain fields.
    typedef struct {
        bit v, rw, as, mw, rs, br;
        bit [1:0] op;
        bit [2:0] f3;
        bit f7;
        bit [31:0] rd1, rd2, imm, pc;
        bit [4:0] s1, s2, d;
    } ex_t;
    ex_t m;
    bit  m_fdc;   // funct fields of an invalid capture are not checked
    int  m_cnt;
    int  checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit hazard();
        if (!ValidD || !m.v || !m.rs || !m.rw || m.d == 0) return 0;
        if (m.d == Rs1D) return 1;
        if ((MemWriteD || !ALUSrcD) && m.d == Rs2D) return 1;
        return 0;
    endfunction

    function automatic void model_reset();
        m = '{default: 0};
        m_fdc = 0;
        m_cnt = 0;
    endfunction

    task automatic compare_all();
        chk("valid_e", ValidE, m.v);       chk("regwrite_e", RegWriteE, m.rw);
        chk("alusrc_e", ALUSrcE, m.as);     chk("memwrite_e", MemWriteE, m.mw);
        chk("resultsrc_e", ResultSrcE, m.rs); chk("branch_e", BranchE, m.br);
        chk("aluop_e", ALUOpE, m.op);
        if (!m_fdc) begin
            chk("funct3_e", funct3E, m.f3); chk("funct7b5_e", funct7b5E, m.f7);
        end
        chk("rd1_e", RD1E, m.rd1);  chk("rd2_e", RD2E, m.rd2);
        chk("imm_e", ImmExtE, m.imm); chk("pc_e", PCE, m.pc);
        chk("rs1_e", Rs1E, m.s1); chk("rs2_e", Rs2E, m.s2); chk("rd_e", RdE, m.d);
        chk("stall_cnt", StallCnt, m_cnt);
    endtask

    // Called just after a rising edge with the next D inputs already applied.
    task automatic tick();
        bit lu;
        @(negedge clk);
        lu = hazard();
        chk("stall_d", StallD, HoldE | (lu & !FlushE));
        @(posedge clk);
        if (FlushE) begin
            m = '{default: 0}; m_fdc = 0;
        end else if (HoldE) begin
        end else if (lu) begin
            m = '{default: 0}; m_fdc = 0;
            if (m_cnt < CMAX) m_cnt++;
        end else begin
            m.v = ValidD; m.rw = RegWriteD & ValidD; m.as = ALUSrcD & ValidD;
            m.mw = MemWriteD & ValidD; m.rs = ResultSrcD & ValidD;
            m.br = BranchD & ValidD; m.op = ValidD ? ALUOpD : 2'b00;
            m.f3 = funct3D; m.f7 = funct7b5D; m_fdc = !ValidD;
            m.rd1 = RD1D; m.rd2 = RD2D; m.imm = ImmExtD; m.pc = PCD;
            m.s1 = Rs1D; m.s2 = Rs2D; m.d = RdD;
        end
        #1;
        compare_all();
    endtask

    task automatic instr(input bit v, rw, as, mw, rsrc, br, input bit [1:0] op,
                         input bit [4:0] s1, s2, d);
        ValidD = v; RegWriteD = rw; ALUSrcD = as; MemWriteD = mw;
        ResultSrcD = rsrc; BranchD = br; ALUOpD = op;
        funct3D = 3'($urandom); funct7b5D = 1'($urandom);
        RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom; PCD = $urandom;
        Rs1D = s1; Rs2D = s2; RdD = d;
    endtask

    task automatic lw6();   instr(1, 1, 1, 0, 1, 0, 2'b00, 5'd2, 5'd0, 5'd6); tick(); endtask
    task automatic add6();  instr(1, 1, 0, 0, 0, 0, 2'b10, 5'd6, 5'd7, 5'd8); tick(); endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    logic [4:0] rd_saved;
    int cnt_saved;

    initial begin
        model_reset();
        FlushE = 0; HoldE = 0;
        instr(0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0);
        #12;
        chk("rst_valid", ValidE, 0); chk("rst_cnt", StallCnt, 0);
        release_reset();

        // Reset asserted mid-cycle clears outputs asynchronously.
        instr(1, 1, 0, 0, 0, 0, 2'b10, 5'd1, 5'd2, 5'd9);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", ValidE, 0); chk("async_regwrite", RegWriteE, 0);
        chk("async_rd", RdE, 0); chk("async_rd1", RD1E, 0); chk("async_cnt", StallCnt, 0);
        model_reset();
        release_reset();

        // Pass-through of an R-type
        instr(1, 1, 0, 0, 0, 0, 2'b10, 5'd1, 5'd2, 5'd5);
        RD1D = 32'h11; RD2D = 32'h22;
        tick();
        chk("pt_regwrite", RegWriteE, 1); chk("pt_aluop", ALUOpE, 2'b10);
        chk("pt_rd1", RD1E, 32'h11); chk("pt_rd2", RD2E, 32'h22);
        chk("pt_rd", RdE, 5); chk("pt_valid", ValidE, 1);

        // Load-use on rs1: one bubble, then the add is captured
        lw6();
        add6();
        chk("lu_bubble_valid", ValidE, 0); chk("lu_bubble_regwrite", RegWriteE, 0);
        tick();
        chk("lu_add_rd", RdE, 8); chk("lu_add_valid", ValidE, 1); chk("lu_cnt", StallCnt, 1);

        // addi reading rs2==6 does not actually use rs2
        lw6();
        instr(1, 1, 1, 0, 0, 0, 2'b10, 5'd3, 5'd6, 5'd9); tick();
        chk("addi_valid", ValidE, 1); chk("addi_cnt", StallCnt, 1);

        // sw uses rs2 as store data
        lw6();
        instr(1, 0, 1, 1, 0, 0, 2'b00, 5'd3, 5'd6, 5'd0); tick();
        chk("sw_bubble", ValidE, 0);
        tick();
        chk("sw_memwrite", MemWriteE, 1); chk("sw_cnt", StallCnt, 2);

        // Load to x0 never stalls
        instr(1, 1, 1, 0, 1, 0, 2'b00, 5'd2, 5'd0, 5'd0); tick();
        instr(1, 1, 0, 0, 0, 0, 2'b10, 5'd0, 5'd0, 5'd4); tick();
        chk("x0_valid", ValidE, 1);

        // Flush a valid beq
        FlushE = 1;
        instr(1, 0, 0, 0, 0, 1, 2'b01, 5'd1, 5'd2, 5'd0); tick();
        FlushE = 0;
        chk("flush_valid", ValidE, 0); chk("flush_branch", BranchE, 0);

        // Hold for 3 cycles, including with a load-use pending
        lw6();
        rd_saved = RdE; cnt_saved = int'(StallCnt);
        HoldE = 1;
        for (int i = 0; i < 3; i++) begin
            instr(1, 1, 0, 0, 0, 0, 2'b10, 5'd6, 5'd6, 5'(10 + i)); tick();
            chk("hold_rd", RdE, rd_saved); chk("hold_stall_d", StallD, 1);
            chk("hold_cnt", StallCnt, cnt_saved);
        end
        FlushE = 1; tick();
        chk("flush_hold_valid", ValidE, 0);
        FlushE = 0; HoldE = 0;

        // Flush with load-use: bubble, no stall, no count
        lw6();
        cnt_saved = int'(StallCnt);
        FlushE = 1;
        add6();
        FlushE = 0;
        chk("flush_lu_valid", ValidE, 0); chk("flush_lu_cnt", StallCnt, cnt_saved);

        // Saturation
        for (int i = 0; i < 20; i++) begin
            lw6(); add6();
            instr(1, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0); tick();
        end
        chk("sat_cnt", StallCnt, 15);

        // Reset in the middle of a load-use stall
        lw6();
        instr(1, 1, 0, 0, 0, 0, 2'b10, 5'd6, 5'd7, 5'd8);
        @(negedge clk);
        chk("pre_rst_stall_d", StallD, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", ValidE, 0); chk("mid_rst_stall_d", StallD, 0);
        chk("mid_rst_cnt", StallCnt, 0); chk("mid_rst_rd", RdE, 0);
        model_reset();
        release_reset();
        tick();
        chk("post_rst_rd", RdE, 8);

        // Random traffic with small register indices to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            instr($urandom_range(0, 9) < 8, 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 2'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)));
            FlushE = ($urandom_range(0, 9) == 0);
            HoldE  = ($urandom_range(0, 99) < 15);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
